switch_conditioner: RTL
=======================

# switch_conditioner

Conditions the raw front-panel push-buttons of the digital clock into clean single-cycle command pulses for the time-control stage, which consumes them as its SW_F1/SW_F2 inputs. Each channel synchronizes its asynchronous switch input, debounces it, emits one pulse per press and, for selected channels, auto-repeats while the button is held. It sits directly upstream of the time-control block, in the same clock domain.

## Interface
- N_SW, 2: number of switch channels; bit 0 feeds SW_F1, bit 1 feeds SW_F2.
- DEBOUNCE_CYC, 4: consecutive stable cycles required to accept a level change (≥1).
- REPEAT_DELAY, 16: hold cycles from the first pulse to the first repeat pulse (≥2).
- REPEAT_RATE, 4: cycles between subsequent repeat pulses (≥2).
- REPEAT_MASK, 2'b10: per-channel auto-repeat enable. The default repeats only channel 1 (value increment).
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-low.
- SW_IN  in  N_SW  raw, asynchronous, bouncing switch levels (1 = pressed).
- SW_LEVEL  out  N_SW  debounced switch level, registered.
- SW_PULSE  out  N_SW  one-cycle command pulse per accepted press or repeat, registered.

## Operation
- Per channel: 2-FF synchronizer (sync1→sync2), debounce counter, accepted level, repeat FSM, repeat counter.
- Debounce:
  - While sync2 equals the accepted level, the counter is held at 0.
  - While they differ, the counter increments each cycle.
  - When the counter equals DEBOUNCE_CYC-1 and the values still differ, the accepted level takes sync2 on that edge and the counter clears.
  - A mismatch shorter than DEBOUNCE_CYC cycles never changes the level.
- Repeat FSM states:
  - IDLE: on an accepted rise, assert SW_PULSE and go to HOLD_WAIT with the counter cleared.
  - HOLD_WAIT: count cycles.
    - If the mask bit is 0, stay here silently until release.
    - If the mask bit is 1 and the count reaches REPEAT_DELAY-1, pulse, clear the counter and go to REPEATING.
  - REPEATING: count cycles; at REPEAT_RATE-1, pulse and clear the counter.
  - Any accepted fall returns the FSM to IDLE from any state, with no pulse and the counter cleared.
- Release never generates a pulse. An accepted rise and a repeat pulse cannot coincide.
- Channels are fully independent. Simultaneous presses on several channels pulse in the same cycle.
- Counter widths are $clog2 of the largest terminal count. Counters saturate by construction; there is no wrap.

## Timing
- Reset (RST=0 at a rising edge) clears sync1, sync2, SW_LEVEL, SW_PULSE and all counters to 0, and forces every FSM to IDLE. This applies mid-debounce and mid-repeat; no pulse is emitted in the reset cycle or the cycle after it.
- A switch held through reset release is a fresh press: its pulse follows the normal latency counted from the first edge with RST=1.
- Press latency: with SW_IN stable high from before edge 0, sync2 is 1 after edge 1. SW_LEVEL and SW_PULSE both assert after edge 1+DEBOUNCE_CYC, which is edge 5 by default. SW_PULSE is high for exactly one cycle.
- Release latency: SW_LEVEL falls DEBOUNCE_CYC+2 edges after SW_IN settles low.
- Repeat pulses fall REPEAT_DELAY cycles after the first pulse, then every REPEAT_RATE cycles. By default these are cycles +16, +20, +24 and so on relative to the first pulse.
- Bounce during a hold, if shorter than DEBOUNCE_CYC, does not disturb the repeat cadence.

## Structure
- clock_pkg holds:
  - the repeat-FSM state typedef (IDLE, HOLD_WAIT, REPEATING);
  - the default constants for DEBOUNCE_CYC, REPEAT_DELAY and REPEAT_RATE, shared with the time-control bench.
- Sub-module switch_channel: synchronizer, debounce and FSM for one channel, parameterized by the repeat-enable bit. switch_conditioner is a generate loop of N_SW instances.

## Test plan
- Reset: hold RST=0 for 3 cycles with SW_IN=2'b11, then release. All outputs are 0 during reset. Both SW_PULSE bits pulse once, 5 edges after release; SW_LEVEL=2'b11.
- Glitch rejection: SW_IN[0] high for 3 cycles, then low. SW_LEVEL[0] and SW_PULSE[0] stay 0 throughout.
- Bouncy press: SW_IN[0] toggles 1,0,1,0 over 4 cycles, then stays high. Exactly one SW_PULSE[0], 5 edges after the final rise. With the mask bit 0, there are no further pulses during a 40-cycle hold.
- Auto-repeat: hold SW_IN[1] for 30 cycles after acceptance. Pulses occur at relative cycles 0, 16, 20, 24 and 28. On release, no pulse; SW_LEVEL[1] falls after 6 edges.
- Reset mid-repeat: assert RST=0 for one cycle at relative cycle 18 while holding. Outputs clear, and the next pulse comes 5 edges after reset release, not at cycle 20.
- Simultaneous press: both bits rise in the same cycle. Both pulse in the same cycle, and each channel's repeat behaviour follows REPEAT_MASK independently.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock front-panel path: repeat-FSM states and
// the default switch timing constants also used by the time-control bench.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEATING = 2'd2
    } rep_state_t;

    localparam int DEBOUNCE_CYC_DEF = 4;
    localparam int REPEAT_DELAY_DEF = 16;
    localparam int REPEAT_RATE_DEF  = 4;

    // Width able to hold terminal count n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/switch_conditioner_if.sv
// Switch bus between the front-panel pins and the time-control stage.
interface switch_conditioner_if #(
    parameter int N_SW = 2
);
    logic [N_SW-1:0] sw_in;
    logic [N_SW-1:0] sw_level;
    logic [N_SW-1:0] sw_pulse;

    modport master (output sw_in, input sw_level, input sw_pulse);
    modport slave  (input sw_in, output sw_level, output sw_pulse);
endinterface

// File: rtl/switch_channel.sv
// One push-button channel: 2-FF synchronizer, debounce, press pulse and
// optional auto-repeat while held.
module switch_channel
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter bit REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_level,
    output logic sw_pulse
);
    localparam int DB_W  = cnt_width(DEBOUNCE_CYC);
    localparam int REP_W = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    logic             sync1_reg, sync2_reg, level_reg;
    logic             pulse_reg, pulse_next;
    logic [DB_W-1:0]  db_cnt_reg;
    logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
    rep_state_t       state_reg, state_next;
    logic             differ, accept, rise, fall;

    assign differ = (sync2_reg != level_reg);
    assign accept = differ && (db_cnt_reg == DB_LAST);
    assign rise   = accept && sync2_reg;
    assign fall   = accept && !sync2_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            level_reg   <= 1'b0;
            db_cnt_reg  <= '0;
            rep_cnt_reg <= '0;
            pulse_reg   <= 1'b0;
            state_reg   <= IDLE;
        end else begin
            sync1_reg <= sw_in;
            sync2_reg <= sync1_reg;
            if (!differ) begin
                db_cnt_reg <= '0;
            end else if (accept) begin
                level_reg  <= sync2_reg;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + DB_W'(1);
            end
            rep_cnt_reg <= rep_cnt_next;
            pulse_reg   <= pulse_next;
            state_reg   <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rep_cnt_next = rep_cnt_reg;
        pulse_next   = 1'b0;
        if (fall) begin
            state_next   = IDLE;
            rep_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        pulse_next   = 1'b1;
                        state_next   = HOLD_WAIT;
                        rep_cnt_next = '0;
                    end
                end
                HOLD_WAIT: begin
                    // Without repeat the count parks at its terminal value.
                    if (rep_cnt_reg != DELAY_LAST) begin
                        rep_cnt_next = rep_cnt_reg + REP_W'(1);
                    end else if (REPEAT_EN) begin
                        pulse_next   = 1'b1;
                        rep_cnt_next = '0;
                        state_next   = REPEATING;
                    end
                end
                REPEATING: begin
                    if (rep_cnt_reg == RATE_LAST) begin
                        pulse_next   = 1'b1;
                        rep_cnt_next = '0;
                    end else begin
                        rep_cnt_next = rep_cnt_reg + REP_W'(1);
                    end
                end
                default: begin
                    state_next   = IDLE;
                    rep_cnt_next = '0;
                end
            endcase
        end
    end

    assign sw_level = level_reg;
    assign sw_pulse = pulse_reg;

endmodule

// File: rtl/switch_conditioner.sv
// Front-panel switch conditioner: N_SW independent channels producing clean
// debounced levels and single-cycle command pulses.
module switch_conditioner
    import clock_pkg::*;
#(
    parameter int              N_SW         = 2,
    parameter int              DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int              REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int              REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter logic [N_SW-1:0] REPEAT_MASK  = 2'b10
) (
    input  logic                 clk,
    input  logic                 rst,
    switch_conditioner_if.slave  bus
);
    logic [N_SW-1:0] level_w;
    logic [N_SW-1:0] pulse_w;

    generate
        for (genvar gi = 0; gi < N_SW; gi++) begin : g_ch
            switch_channel #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC),
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_RATE  (REPEAT_RATE),
                .REPEAT_EN    (REPEAT_MASK[gi])
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .sw_in    (bus.sw_in[gi]),
                .sw_level (level_w[gi]),
                .sw_pulse (pulse_w[gi])
            );
        end
    endgenerate

    assign bus.sw_level = level_w;
    assign bus.sw_pulse = pulse_w;

endmodule
